aes_mode_engine: RTL and testbench

AES_MODE_ENGINE -- requirements
Module: aes_mode_engine

---
 rtl/aes_mode_pkg.sv | 22 ++
 rtl/aes_ctr_inc.sv | 23 ++
 rtl/aes_mode_engine.sv | 169 ++++++++++++++++
 tb/tb_aes_mode_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mode_pkg.sv
// Shared constants for the AES block-mode engine: block width, mode encodings,
// FSM state encodings and the mode legality helper.
package aes_mode_pkg;

    localparam int unsigned BLK_W = 128;

    localparam logic [1:0] MODE_ECB = 2'b00;
    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CTR = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_IN = 2'd1;
    localparam logic [1:0] ST_CORE    = 2'd2;
    localparam logic [1:0] ST_OUT     = 2'd3;

    // CTR only counts as legal when the build includes counter support.
    function automatic logic mode_legal(input logic [1:0] m, input logic ctr_en);
        return (m == MODE_ECB) || (m == MODE_CBC) || (ctr_en && (m == MODE_CTR));
    endfunction

endpackage

// File: rtl/aes_ctr_inc.sv
// Masked counter-block incrementer: the low CTR_W bits count modulo 2^CTR_W,
// the upper bits of the block pass through untouched.
module aes_ctr_inc
    import aes_mode_pkg::*;
#(
    parameter int unsigned CTR_W = 32
) (
    input  logic [BLK_W-1:0] ctr_in,
    output logic [BLK_W-1:0] ctr_out
);

    localparam logic [BLK_W-1:0] LOW_MASK =
        (CTR_W >= BLK_W) ? '1 : ((BLK_W'(1) << CTR_W) - BLK_W'(1));

    logic [BLK_W-1:0] ctr_plus;

    // Carry out of the counted field is discarded by the mask.
    always_comb begin
        ctr_plus = ctr_in + BLK_W'(1);
        ctr_out  = (ctr_in & ~LOW_MASK) | (ctr_plus & LOW_MASK);
    end

endmodule

// File: rtl/aes_mode_engine.sv
// ECB/CBC/CTR chaining wrapper around an external AES cipher core.
// Define AES_MODE_CTR_EN to build CTR mode support.
module aes_mode_engine
    import aes_mode_pkg::*;
#(
    parameter int unsigned CTR_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             encrypt_n_decrypt,
    input  logic [BLK_W-1:0] key,
    input  logic [BLK_W-1:0] iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             core_start,
    output logic             core_dec,
    output logic [BLK_W-1:0] core_key,
    output logic [BLK_W-1:0] core_din,
    input  logic [BLK_W-1:0] core_dout,
    input  logic             core_done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] blk_cnt
);

`ifdef AES_MODE_CTR_EN
    localparam logic CTR_EN = 1'b1;
`else
    localparam logic CTR_EN = 1'b0;
`endif

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic             enc_q;
    logic [BLK_W-1:0] key_q;
    logic [BLK_W-1:0] chain_q;
    logic [BLK_W-1:0] data_q;
    logic             last_q;

    logic [BLK_W-1:0] core_din_next;
    logic             core_dec_next;
    logic [BLK_W-1:0] result;
    logic [BLK_W-1:0] chain_next;

`ifdef AES_MODE_CTR_EN
    logic [BLK_W-1:0] ctr_next;

    aes_ctr_inc #(
        .CTR_W (CTR_W)
    ) u_ctr_inc (
        .ctr_in  (chain_q),
        .ctr_out (ctr_next)
    );
`endif

    assign in_ready = (state == ST_WAIT_IN);
    assign busy     = (state != ST_IDLE);
    assign core_key = key_q;

    always_comb begin
        core_din_next = in_data;
        core_dec_next = ~enc_q;
        if (mode_q == MODE_CBC && enc_q) begin
            core_din_next = in_data ^ chain_q;
        end
`ifdef AES_MODE_CTR_EN
        if (mode_q == MODE_CTR) begin
            core_din_next = chain_q;
            core_dec_next = 1'b0;
        end
`endif
    end

    // chain_q is the CBC chaining value or the CTR counter block.
    always_comb begin
        result     = core_dout;
        chain_next = chain_q;
        if (mode_q == MODE_CBC) begin
            if (enc_q) begin
                chain_next = core_dout;
            end else begin
                result     = core_dout ^ chain_q;
                chain_next = data_q;
            end
        end
`ifdef AES_MODE_CTR_EN
        if (mode_q == MODE_CTR) begin
            result     = core_dout ^ data_q;
            chain_next = ctr_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_ECB;
            enc_q      <= 1'b0;
            key_q      <= '0;
            chain_q    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            core_start <= 1'b0;
            core_din   <= '0;
            core_dec   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            err        <= 1'b0;
            blk_cnt    <= '0;
        end else begin
            core_start <= 1'b0;
            err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode_legal(mode, CTR_EN)) begin
                            mode_q  <= mode;
                            enc_q   <= encrypt_n_decrypt;
                            key_q   <= key;
                            chain_q <= iv;
                            blk_cnt <= '0;
                            state   <= ST_WAIT_IN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        last_q     <= in_last;
                        core_din   <= core_din_next;
                        core_dec   <= core_dec_next;
                        core_start <= 1'b1;
                        state      <= ST_CORE;
                    end
                end
                ST_CORE: begin
                    if (core_done) begin
                        out_data  <= result;
                        out_last  <= last_q;
                        out_valid <= 1'b1;
                        blk_cnt   <= blk_cnt + CNT_W'(1);
                        chain_q   <= chain_next;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= out_last ? ST_IDLE : ST_WAIT_IN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mode_engine.sv
// Directed bench for aes_mode_engine; the bench plays the cipher core using
// FIPS-197 / SP800-38A reference vectors.
module tb_aes_mode_engine;

    localparam logic [127:0] KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1      = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] ECB1     = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] CBC_IV   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CBC1     = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CBC2     = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] CTR_IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] KS1      = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] KS2      = 128'h362b7c3c6773516318a077d7fc5073ae;
    localparam logic [127:0] CTR_OUT1 = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CTR_OUT2 = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] CTR2_W8  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe00;
    localparam logic [127:0] CTR2_W32 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         encrypt_n_decrypt = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    logic         core_start;
    logic         core_dec;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic [127:0] core_dout = '0;
    logic         core_done = 1'b0;
    logic         busy;
    logic         err;
    logic [15:0]  blk_cnt;
    logic [127:0] inc8_out;
    logic [127:0] inc32_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    aes_mode_engine #(
        .CTR_W (8),
        .CNT_W (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mode              (mode),
        .encrypt_n_decrypt (encrypt_n_decrypt),
        .key               (key),
        .iv                (iv),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_last           (in_last),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .core_start        (core_start),
        .core_dec          (core_dec),
        .core_key          (core_key),
        .core_din          (core_din),
        .core_dout         (core_dout),
        .core_done         (core_done),
        .busy              (busy),
        .err               (err),
        .blk_cnt           (blk_cnt)
    );

    aes_ctr_inc #(.CTR_W (8))  u_inc8  (.ctr_in (CTR_IV), .ctr_out (inc8_out));
    aes_ctr_inc #(.CTR_W (32)) u_inc32 (.ctr_in (CTR_IV), .ctr_out (inc32_out));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic begin_session(input logic [1:0] m, input logic enc,
                                 input logic [127:0] k, input logic [127:0] v);
        start = 1'b1; mode = m; encrypt_n_decrypt = enc; key = k; iv = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_block(input string tag, input logic [127:0] d, input logic l,
                              input logic [127:0] exp_din, input logic exp_dec);
        int unsigned n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " core_start"}, 128'(core_start), 128'(1'b1));
        check({tag, " core_din"}, core_din, exp_din);
        check({tag, " core_dec"}, 128'(core_dec), 128'(exp_dec));
        check({tag, " core_key"}, core_key, KEY);
    endtask

    task automatic finish_core(input string tag, input int unsigned lat,
                               input logic [127:0] exp_din, input logic [127:0] dout);
        @(negedge clk);
        check({tag, " core_start pulse"}, 128'(core_start), 128'(1'b0));
        check({tag, " core_din held"}, core_din, exp_din);
        repeat (lat - 1) @(negedge clk);
        core_done = 1'b1; core_dout = dout;
        @(negedge clk);
        core_done = 1'b0; core_dout = '0;
    endtask

    task automatic pop_block(input string tag, input logic [127:0] exp, input logic exp_last,
                             input int unsigned hold);
        repeat (hold) begin
            check({tag, " hold out_valid"}, 128'(out_valid), 128'(1'b1));
            check({tag, " hold out_data"}, out_data, exp);
            check({tag, " hold in_ready"}, 128'(in_ready), 128'(1'b0));
            check({tag, " hold core_start"}, 128'(core_start), 128'(1'b0));
            @(negedge clk);
        end
        check({tag, " out_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, " out_data"}, out_data, exp);
        check({tag, " out_last"}, 128'(out_last), 128'(exp_last));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst busy", 128'(busy), '0);
        check("rst out_valid", 128'(out_valid), '0);
        check("rst out_data", out_data, '0);
        check("rst in_ready", 128'(in_ready), '0);
        check("rst core_start", 128'(core_start), '0);
        check("rst core_din", core_din, '0);
        check("rst core_key", core_key, '0);
        check("rst err", 128'(err), '0);
        check("rst blk_cnt", 128'(blk_cnt), '0);
        reset = 1'b1;
        @(negedge clk);

        // ECB encrypt, single block
        begin_session(2'b00, 1'b1, KEY, '0);
        check("ecb busy", 128'(busy), 128'(1'b1));
        check("ecb core_key", core_key, KEY);
        push_block("ecb", PT1, 1'b1, PT1, 1'b0);
        finish_core("ecb", 2, PT1, ECB1);
        pop_block("ecb", ECB1, 1'b1, 0);
        check("ecb blk_cnt", 128'(blk_cnt), 128'(16'd1));
        check("ecb idle busy", 128'(busy), '0);

        // CBC encrypt, two blocks, back-pressure on the first
        begin_session(2'b01, 1'b1, KEY, CBC_IV);
        check("cbc blk_cnt clear", 128'(blk_cnt), '0);
        push_block("cbc1", PT1, 1'b0, PT1 ^ CBC_IV, 1'b0);
        finish_core("cbc1", 1, PT1 ^ CBC_IV, CBC1);
        pop_block("cbc1", CBC1, 1'b0, 5);
        check("cbc wait in_ready", 128'(in_ready), 128'(1'b1));
        begin_session(2'b00, 1'b1, ~KEY, '0);
        check("wait start err", 128'(err), '0);
        check("wait start in_ready", 128'(in_ready), 128'(1'b1));
        check("wait start blk_cnt", 128'(blk_cnt), 128'(16'd1));
        check("wait start key", core_key, KEY);
        core_done = 1'b1; core_dout = ECB1;
        @(negedge clk);
        core_done = 1'b0; core_dout = '0;
        check("stray done out_valid", 128'(out_valid), '0);
        push_block("cbc2", PT2, 1'b1, PT2 ^ CBC1, 1'b0);
        finish_core("cbc2", 3, PT2 ^ CBC1, CBC2);
        pop_block("cbc2", CBC2, 1'b1, 0);
        check("cbc blk_cnt", 128'(blk_cnt), 128'(16'd2));

        // CBC decrypt
        begin_session(2'b01, 1'b0, KEY, CBC_IV);
        push_block("cbcd", CBC1, 1'b1, CBC1, 1'b1);
        finish_core("cbcd", 2, CBC1, PT1 ^ CBC_IV);
        pop_block("cbcd", PT1, 1'b1, 0);

        // illegal mode
        begin_session(2'b11, 1'b1, KEY, '0);
        check("ill err", 128'(err), 128'(1'b1));
        check("ill busy", 128'(busy), '0);
        @(negedge clk);
        check("ill err pulse", 128'(err), '0);
        check("ill busy2", 128'(busy), '0);

`ifdef AES_MODE_CTR_EN
        // CTR with decrypt direction still drives the core forward
        begin_session(2'b10, 1'b0, KEY, CTR_IV);
        push_block("ctr1", PT1, 1'b0, CTR_IV, 1'b0);
        finish_core("ctr1", 2, CTR_IV, KS1);
        pop_block("ctr1", CTR_OUT1, 1'b0, 0);
        push_block("ctr2", PT2, 1'b1, CTR2_W8, 1'b0);
        finish_core("ctr2", 2, CTR2_W8, KS2);
        pop_block("ctr2", CTR_OUT2, 1'b1, 0);
        check("ctr blk_cnt", 128'(blk_cnt), 128'(16'd2));
`else
        begin_session(2'b10, 1'b1, KEY, CTR_IV);
        check("ctr off err", 128'(err), 128'(1'b1));
        check("ctr off busy", 128'(busy), '0);
`endif

        // reset during CORE abandons the block
        begin_session(2'b00, 1'b1, KEY, '0);
        push_block("rstc", PT1, 1'b1, PT1, 1'b0);
        reset = 1'b0;
        #1;
        check("rstc async busy", 128'(busy), '0);
        check("rstc async core_din", core_din, '0);
        @(negedge clk);
        reset = 1'b1;
        core_done = 1'b1; core_dout = ECB1;
        @(negedge clk);
        core_done = 1'b0; core_dout = '0;
        @(negedge clk);
        check("rstc out_valid", 128'(out_valid), '0);
        check("rstc busy", 128'(busy), '0);
        check("rstc in_ready", 128'(in_ready), '0);
        check("rstc out_data", out_data, '0);
        check("rstc out_last", 128'(out_last), '0);
        check("rstc core_din", core_din, '0);
        check("rstc core_dec", 128'(core_dec), '0);
        check("rstc core_key", core_key, '0);
        check("rstc blk_cnt", 128'(blk_cnt), '0);
        check("rstc err", 128'(err), '0);

        check("inc8 wrap", inc8_out, CTR2_W8);
        check("inc32 carry", inc32_out, CTR2_W32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
